// File: rtl/f_fetch_pc_if.sv
// Fetch-PC bus: the control inputs from CP0, the hazard unit and the D-stage branch
// logic, plus the F-stage word that the F/D register captures.
interface f_fetch_pc_if #(
  parameter int DATA_W = 32
);
  logic              block;
  logic              Req;
  logic              D_eret;
  logic [DATA_W-1:0] EPC;
  logic              D_br_take;
  logic [DATA_W-1:0] D_br_target;
  logic              F_isBJ;
  logic [DATA_W-1:0] F_pc;
  logic [4:0]        F_ExcCode;
  logic              F_isBD;
  logic [DATA_W-1:0] F_fetch_cnt;

  // Fetch PC generator side.
  modport slave (
    input  block, Req, D_eret, EPC, D_br_take, D_br_target, F_isBJ,
    output F_pc, F_ExcCode, F_isBD, F_fetch_cnt
  );

  // Pipeline control side driving the generator.
  modport master (
    output block, Req, D_eret, EPC, D_br_take, D_br_target, F_isBJ,
    input  F_pc, F_ExcCode, F_isBD, F_fetch_cnt
  );
endinterface

// File: rtl/f_fetch_pc.sv
// Fetch-stage PC generator. Keeps pc, delay-slot flag and advance counter, and
// follows the same stall/exception/eret priority as the F/D pipeline register so
// F and D never disagree about which word was fetched.
module f_fetch_pc #(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI  = 32'h0000_6ffc
) (
  input  logic         clk,
  input  logic         reset,
  f_fetch_pc_if.slave  bus
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Which rule decides the next F-stage word this cycle.
  typedef enum logic [2:0] {
    SRC_HOLD = 3'd0,
    SRC_EXC  = 3'd1,
    SRC_ERET = 3'd2,
    SRC_BR   = 3'd3,
    SRC_SEQ  = 3'd4
  } src_e;

  logic [DATA_W-1:0] pc_q,  pc_d;
  logic              isbd_q, isbd_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] pc_seq;
  src_e              src;

  // Misaligned or outside the text window -> address error on load (AdEL).
  function automatic logic is_adel(input logic [DATA_W-1:0] pc);
    return (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);
  endfunction

  // Sequential successor; wraps silently, the wrapped pc then shows up as AdEL.
  function automatic logic [DATA_W-1:0] pc_plus4(input logic [DATA_W-1:0] pc);
    return pc + DATA_W'(4);
  endfunction

  assign pc_seq = pc_plus4(pc_q);

  // Priority decode: Req beats a stall, a stall masks eret/branch, eret beats branch.
  always_comb begin
    src = SRC_SEQ;
    if (bus.Req)            src = SRC_EXC;
    else if (bus.block)     src = SRC_HOLD;
    else if (bus.D_eret)    src = SRC_ERET;
    else if (bus.D_br_take) src = SRC_BR;
    else                    src = SRC_SEQ;
  end

  // Next-state values for pc, delay-slot flag and advance counter.
  always_comb begin
    pc_d   = pc_q;
    isbd_d = isbd_q;
    cnt_d  = cnt_q;
    unique case (src)
      SRC_EXC: begin
        // Exception redirect is not an advance of the fetch stream.
        pc_d   = EXC_PC;
        isbd_d = 1'b0;
      end
      SRC_HOLD: begin
        pc_d   = pc_q;
        isbd_d = isbd_q;
      end
      SRC_ERET: begin
        pc_d   = EPC_val();
        isbd_d = 1'b0;
        cnt_d  = cnt_q + DATA_W'(1);
      end
      SRC_BR: begin
        pc_d   = bus.D_br_target;
        isbd_d = 1'b0;
        cnt_d  = cnt_q + DATA_W'(1);
      end
      SRC_SEQ: begin
        // The word after a branch/jump is its delay slot.
        pc_d   = pc_seq;
        isbd_d = bus.F_isBJ;
        cnt_d  = cnt_q + DATA_W'(1);
      end
      default: begin
        pc_d   = pc_q;
        isbd_d = isbd_q;
        cnt_d  = cnt_q;
      end
    endcase
  end

  function automatic logic [DATA_W-1:0] EPC_val();
    return bus.EPC;
  endfunction

  // F-stage state register; reset overrides stall and Req and leaves nothing behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      isbd_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      isbd_q <= isbd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.F_pc        = pc_q;
  assign bus.F_isBD      = isbd_q;
  assign bus.F_fetch_cnt = cnt_q;
  assign bus.F_ExcCode   = is_adel(pc_q) ? EXC_ADEL : EXC_NONE;

endmodule
